// File: rtl/draw_counter_pkg.sv
// Shared definitions for the pixel sweeper: region codes, FSM states, region sizes.
// Region codes match the encoding used by the downstream address stage.
// Ports: none (package only).
package draw_counter_pkg;

   localparam int FS_W = 160;
   localparam int FS_H = 120;
   localparam int CV_W = 115;
   localparam int CV_H = 70;
   localparam int AN_W = 21;
   localparam int AN_H = 17;

   localparam logic [1:0] FULLSCREEN = 2'b00;
   localparam logic [1:0] CANVAS     = 2'b01;
   localparam logic [1:0] ANSWER     = 2'b10;
   localparam logic [1:0] INVALID    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_DRAW = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Fullscreen columns start at 1 because the address stage subtracts 1 in that mode.
   function automatic logic [7:0] first_col(input logic [1:0] region);
      return (region == FULLSCREEN) ? 8'd1 : 8'd0;
   endfunction

endpackage

// File: rtl/draw_counter_region_limits.sv
// Purpose: maps a latched region code to its first column, last column and last row.
// Latency: purely combinational. Backpressure: none.
// Ports: mode (region code in), first_x / last_x (column bounds out), last_y (last row out).
module region_limits
   import draw_counter_pkg::*;
(
   input  logic [1:0] mode,
   output logic [7:0] first_x,
   output logic [7:0] last_x,
   output logic [6:0] last_y
);

   always_comb begin
      first_x = first_col(mode);
      last_x  = 8'd0;
      last_y  = 7'd0;
      case (mode)
         FULLSCREEN: begin
            last_x = 8'(FS_W);
            last_y = 7'(FS_H - 1);
         end
         CANVAS: begin
            last_x = 8'(CV_W - 1);
            last_y = 7'(CV_H - 1);
         end
         ANSWER: begin
            last_x = 8'(AN_W - 1);
            last_y = 7'(AN_H - 1);
         end
         // The invalid code is never latched; collapse to a single pixel.
         default: begin
            last_x = first_col(mode);
            last_y = 7'd0;
         end
      endcase
   end

endmodule

// File: rtl/draw_counter.sv
// Purpose: row-major sweep of a region rectangle, one (Xpos, Ypos) offset plus plot per cycle.
// Latency: first plot one cycle after an accepted go; done one cycle after the last plot.
// Backpressure: hold freezes coordinate and state and drops plot; no pixel is skipped.
// Ports: clock, reset (async high), go/aluOp (start + region), hold (stall),
//        Xpos/Ypos (offsets), mode (latched region), plot/busy/done (status).
module draw_counter
   import draw_counter_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       go,
   input  logic [1:0] aluOp,
   input  logic       hold,
   output logic [7:0] Xpos,
   output logic [6:0] Ypos,
   output logic [1:0] mode,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] x_nxt;
   logic [6:0] y_nxt;
   logic [1:0] mode_nxt;
   logic [7:0] first_x;
   logic [7:0] last_x;
   logic [6:0] last_y;

   region_limits u_limits (
      .mode    (mode),
      .first_x (first_x),
      .last_x  (last_x),
      .last_y  (last_y)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         Xpos  <= 8'd0;
         Ypos  <= 7'd0;
         mode  <= FULLSCREEN;
      end else begin
         state <= state_nxt;
         Xpos  <= x_nxt;
         Ypos  <= y_nxt;
         mode  <= mode_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      x_nxt     = Xpos;
      y_nxt     = Ypos;
      mode_nxt  = mode;
      plot      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            x_nxt = 8'd0;
            y_nxt = 7'd0;
            if (go && aluOp != INVALID) begin
               state_nxt = ST_DRAW;
               mode_nxt  = aluOp;
               // Limits follow the latched mode, so the first column comes from aluOp here.
               x_nxt     = first_col(aluOp);
            end
         end
         ST_DRAW: begin
            busy = 1'b1;
            if (!hold) begin
               plot = 1'b1;
               if (Xpos == last_x) begin
                  if (Ypos == last_y) begin
                     // Coordinates stay parked on the last pixel through DONE.
                     state_nxt = ST_DONE;
                  end else begin
                     x_nxt = first_x;
                     y_nxt = Ypos + 7'd1;
                  end
               end else begin
                  x_nxt = Xpos + 8'd1;
               end
            end
         end
         ST_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = ST_IDLE;
            x_nxt     = 8'd0;
            y_nxt     = 7'd0;
         end
         default: begin
            state_nxt = ST_IDLE;
            x_nxt     = 8'd0;
            y_nxt     = 7'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_draw_counter.sv
// Purpose: randomized self-checking bench for draw_counter against a pixel-list model.
// Latency: inputs driven at the falling edge, outputs sampled 1 time unit later.
// Ports: none (top-level bench).
module tb_draw_counter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       go    = 1'b0;
   logic [1:0] aluOp = 2'b00;
   logic       hold  = 1'b0;
   logic [7:0] Xpos;
   logic [6:0] Ypos;
   logic [1:0] mode;
   logic       plot;
   logic       busy;
   logic       done;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
   } pix_t;

   pix_t       exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [1:0] model_mode = 2'b00;

   draw_counter dut (
      .clock (clock),
      .reset (reset),
      .go    (go),
      .aluOp (aluOp),
      .hold  (hold),
      .Xpos  (Xpos),
      .Ypos  (Ypos),
      .mode  (mode),
      .plot  (plot),
      .busy  (busy),
      .done  (done)
   );

   always #5 clock = ~clock;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // Region geometry straight from the region table.
   task automatic get_dims(input logic [1:0] op, output int w, output int h, output int x0);
      case (op)
         2'b00:   begin w = 160; h = 120; x0 = 1; end
         2'b01:   begin w = 115; h = 70;  x0 = 0; end
         default: begin w = 21;  h = 17;  x0 = 0; end
      endcase
   endtask

   // Drives one sweep of region op. hold_pct: random stall probability; noise: random
   // go/aluOp during the sweep; (sx,sy,slen): forced stall; chain: keep go high across
   // DONE->IDLE with chain_op; (ax,ay): assert reset when this pixel is current.
   task automatic run_sweep(input logic [1:0] op, input int hold_pct, input bit noise,
                            input int sx, input int sy, input int slen,
                            input bit chain, input logic [1:0] chain_op,
                            input int ax, input int ay);
      int   w, h, x0, plots, cycles, stall_left;
      pix_t p;
      bit   hv;
      get_dims(op, w, h, x0);
      exp_q.delete();
      for (int y = 0; y < h; y++)
         for (int x = x0; x < x0 + w; x++) begin
            p.x = 8'(x);
            p.y = 7'(y);
            exp_q.push_back(p);
         end

      // IDLE cycle on which go is accepted.
      @(negedge clock);
      go    = 1'b1;
      aluOp = op;
      hold  = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (busy !== 1'b0 || plot !== 1'b0 || done !== 1'b0 || Xpos !== 8'd0 || Ypos !== 7'd0) begin
         n_bad++;
         $display("FAIL idle_before_go: busy=%b plot=%b done=%b x=%0d y=%0d, want 0 0 0 0 0",
                  busy, plot, done, Xpos, Ypos);
      end
      model_mode = op;

      stall_left = slen;
      plots      = 0;
      cycles     = 0;
      while (exp_q.size() > 0 && cycles < w * h * 4 + 50) begin
         @(negedge clock);
         cycles++;
         p  = exp_q[0];
         hv = ($urandom_range(0, 99) < hold_pct);
         if (stall_left > 0 && int'(p.x) == sx && int'(p.y) == sy) begin
            hv = 1'b1;
            stall_left--;
         end
         hold = hv;
         if (noise) begin
            go    = 1'($urandom_range(0, 1));
            aluOp = 2'($urandom_range(0, 3));
         end else begin
            go    = 1'b0;
            aluOp = op;
         end
         #1;
         if (ax >= 0 && int'(p.x) == ax && int'(p.y) == ay) begin
            reset = 1'b1;
            #1;
            n_cmp++;
            if (busy !== 1'b0 || plot !== 1'b0 || done !== 1'b0 || Xpos !== 8'd0 ||
                Ypos !== 7'd0 || mode !== 2'b00) begin
               n_bad++;
               $display("FAIL async_reset: busy=%b plot=%b done=%b x=%0d y=%0d mode=%0d, want all 0",
                        busy, plot, done, Xpos, Ypos, mode);
            end
            model_mode = 2'b00;
            @(negedge clock);
            reset = 1'b0;
            go    = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clock);
               #1;
               n_cmp++;
               if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0) begin
                  n_bad++;
                  $display("FAIL post_reset_idle: busy=%b done=%b plot=%b, want 0 0 0",
                           busy, done, plot);
               end
            end
            return;
         end
         n_cmp++;
         if (busy !== 1'b1 || done !== 1'b0 || mode !== op || plot !== !hv ||
             Xpos !== p.x || Ypos !== p.y) begin
            n_bad++;
            $display("FAIL draw_px: got x=%0d y=%0d plot=%b busy=%b done=%b mode=%0d, want x=%0d y=%0d plot=%b busy=1 done=0 mode=%0d",
                     Xpos, Ypos, plot, busy, done, mode, p.x, p.y, !hv, op);
         end
         if (!hv) begin
            void'(exp_q.pop_front());
            plots++;
         end
      end

      n_cmp++;
      if (exp_q.size() != 0 || plots != w * h) begin
         n_bad++;
         $display("FAIL plot_count: got %0d plots (%0d left), want %0d", plots, exp_q.size(), w * h);
      end

      // DONE cycle.
      @(negedge clock);
      hold = 1'($urandom_range(0, 1));
      if (chain) begin
         go    = 1'b1;
         aluOp = chain_op;
      end else begin
         go    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         aluOp = 2'($urandom_range(0, 3));
      end
      #1;
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b1 || plot !== 1'b0 || mode !== op ||
          int'(Xpos) != x0 + w - 1 || int'(Ypos) != h - 1) begin
         n_bad++;
         $display("FAIL done_cycle: done=%b busy=%b plot=%b x=%0d y=%0d mode=%0d, want 1 1 0 x=%0d y=%0d mode=%0d",
                  done, busy, plot, Xpos, Ypos, mode, x0 + w - 1, h - 1, op);
      end

      if (!chain) begin
         for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            go    = 1'b0;
            aluOp = 2'($urandom_range(0, 3));
            hold  = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0 || Xpos !== 8'd0 ||
                Ypos !== 7'd0 || mode !== op) begin
               n_bad++;
               $display("FAIL after_done_idle: busy=%b done=%b plot=%b x=%0d y=%0d mode=%0d, want 0 0 0 0 0 mode=%0d",
                        busy, done, plot, Xpos, Ypos, mode, op);
            end
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      go    = 1'b0;
      #3;
      n_cmp++;
      if (busy !== 1'b0 || plot !== 1'b0 || done !== 1'b0 || Xpos !== 8'd0 ||
          Ypos !== 7'd0 || mode !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_state: busy=%b plot=%b done=%b x=%0d y=%0d mode=%0d, want all 0",
                  busy, plot, done, Xpos, Ypos, mode);
      end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_mode = 2'b00;
   endtask

   task automatic test_answer_sweep;
      run_sweep(2'b10, 0, 1'b0, -1, -1, 0, 1'b0, 2'b00, -1, -1);
   endtask

   task automatic test_fullscreen_sweep;
      run_sweep(2'b00, 0, 1'b0, -1, -1, 0, 1'b0, 2'b00, -1, -1);
   endtask

   task automatic test_stall;
      run_sweep(2'b01, 0, 1'b0, 57, 3, 5, 1'b0, 2'b00, -1, -1);
   endtask

   task automatic test_random_hold;
      run_sweep(2'b10, 35, 1'b0, -1, -1, 0, 1'b0, 2'b00, -1, -1);
   endtask

   task automatic test_ignored_requests;
      run_sweep(2'b10, 20, 1'b1, -1, -1, 0, 1'b0, 2'b00, -1, -1);
   endtask

   task automatic test_invalid_op;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         go    = 1'b1;
         aluOp = 2'b11;
         hold  = 1'($urandom_range(0, 1));
         #1;
         n_cmp++;
         if (busy !== 1'b0 || plot !== 1'b0 || done !== 1'b0 || mode !== model_mode) begin
            n_bad++;
            $display("FAIL invalid_op: busy=%b plot=%b done=%b mode=%0d, want 0 0 0 mode=%0d",
                     busy, plot, done, mode, model_mode);
         end
      end
      @(negedge clock);
      go = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || plot !== 1'b0) begin
         n_bad++;
         $display("FAIL invalid_op_settle: busy=%b plot=%b, want 0 0", busy, plot);
      end
   endtask

   task automatic test_back_to_back;
      run_sweep(2'b10, 0, 1'b1, -1, -1, 0, 1'b1, 2'b01, -1, -1);
      run_sweep(2'b01, 10, 1'b0, -1, -1, 0, 1'b0, 2'b00, -1, -1);
   endtask

   task automatic test_reset_mid_sweep;
      run_sweep(2'b01, 0, 1'b0, -1, -1, 0, 1'b0, 2'b00, 10, 5);
      run_sweep(2'b10, 0, 1'b0, -1, -1, 0, 1'b0, 2'b00, -1, -1);
   endtask

   initial begin
      test_reset;
      test_answer_sweep;
      test_fullscreen_sweep;
      test_stall;
      test_random_hold;
      test_ignored_requests;
      test_invalid_op;
      test_back_to_back;
      test_reset_mid_sweep;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/draw_counter.md
Name: draw_counter

Overview:
- Sequential pixel sweeper directly upstream of the address ALU stage.
- On a `go` pulse it latches a region mode and walks a rectangle of that region's size, row-major.
- Each cycle it emits one (Xpos, Ypos) offset plus a plot strobe; the address stage adds these to startX/startY.
- It pulses `done` once after the last pixel, so the control FSM can sequence fullscreen clears, canvas redraws and answer tiles.

Parameters:
- FS_W, 160, fullscreen width in pixels
- FS_H, 120, fullscreen height in pixels
- CV_W, 115, canvas width
- CV_H, 70, canvas height
- AN_W, 21, answer tile width
- AN_H, 17, answer tile height

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- go  input  1  start request; sampled only in IDLE
- aluOp  input  2  region select: 00 fullscreen, 01 canvas, 10 answer, 11 invalid
- hold  input  1  stall; freezes the sweep while high
- Xpos  output  8  current column offset
- Ypos  output  7  current row offset
- mode  output  2  aluOp latched at go; drives the address stage's aluOp during a sweep
- plot  output  1  high when Xpos/Ypos form a valid pixel to write this cycle
- busy  output  1  high in DRAW and DONE
- done  output  1  single-cycle completion pulse

Behaviour:
- Reset values (asynchronous): state IDLE; Xpos=0, Ypos=0, mode=00, plot=0, busy=0, done=0. Reset mid-sweep aborts immediately with no done pulse.
- States: IDLE, DRAW, DONE.
- IDLE:
  - go=1 with aluOp in {00,01,10}: next edge latches mode=aluOp, loads the first pixel, enters DRAW.
  - go=1 with aluOp=11: ignored; stays IDLE.
- First pixel: Ypos=0. Xpos=1 in fullscreen mode, because the address stage subtracts 1 in that mode; Xpos=0 otherwise.
- Column range per mode: fullscreen 1..FS_W; canvas 0..CV_W-1; answer 0..AN_W-1.
- DRAW with hold=0:
  - plot=1 for the current coordinate.
  - On the edge, Xpos increments.
  - At the last column, Xpos wraps to the mode's first column and Ypos increments.
  - At last column and last row (Ypos=H-1), the next state is DONE. Xpos/Ypos hold the last pixel; they are not advanced.
- DRAW with hold=1: plot=0; Xpos, Ypos and state frozen. When hold drops, the same coordinate is plotted; no pixel is skipped or duplicated.
- DONE: done=1, plot=0, busy=1 for exactly one cycle, then IDLE. Xpos/Ypos return to 0 on entering IDLE.
- Latency: go edge to first plot=1 is 1 cycle. A sweep with no stalls produces exactly W*H plot cycles. done is asserted on the cycle after the last plot.
- go during DRAW/DONE is ignored; there is no queueing. go held high across DONE→IDLE starts a new sweep on the first IDLE cycle.
- aluOp changes during a sweep have no effect; mode stays latched until the next accepted go.
- Arithmetic: counters sized to ports; Xpos never exceeds 160, Ypos never exceeds 119. Comparisons are against the per-mode last-column/last-row constants, with no overflow wrap.
- plot is combinational from state and hold: (state==DRAW && !hold).

Decomposition:
- Shared package holds:
  - region codes FULLSCREEN=2'b00, CANVAS=2'b01, ANSWER=2'b10 (same encoding the address stage uses);
  - state encoding IDLE/DRAW/DONE;
  - the six dimension constants.
- One natural sub-module: region_limits (combinational). It maps mode to first_x, last_x and last_y. The FSM and counters stay in draw_counter.

Test Plan:
- Answer sweep: reset, go with aluOp=10, hold=0 → first plot cycle (0,0) one cycle after go; 357 plot cycles; last plot (20,16); done high exactly once, on the next cycle; busy low after.
- Fullscreen sweep: aluOp=00 → first plot (1,0); row wrap from (160,0) to (1,1); 19200 plots; last (160,119); done pulse.
- Stall: canvas sweep, hold=1 for 5 cycles at (57,3) → plot=0 for those cycles, coordinate unchanged; next plot is (57,3) then (58,3); total plots still 8050.
- Ignored requests:
  - go pulses during DRAW → single done, no restart.
  - aluOp=11 in IDLE → busy stays 0, no plot.
  - aluOp toggled mid-sweep → mode unchanged.
- Asynchronous reset asserted mid-sweep at (10,5) between edges → all outputs 0 immediately; no done. A go after release starts a fresh sweep at (0,0).
